// File: rtl/chipdev_pkg.sv
// Shared constants and sizing helpers for the running-statistics front end.
package chipdev_pkg;

    localparam int unsigned DEFAULT_DATA_SIZE = 32'd32;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 32'd1) ? $clog2(depth) : 32'd1;
    endfunction

endpackage

// File: rtl/serial_word_packer_fifo.sv
// Synchronous word FIFO with a registered head word, occupancy count and same-cycle push/pop.
module word_fifo
    import chipdev_pkg::*;
#(
    parameter int unsigned DW    = 32'd32,
    parameter int unsigned DEPTH = 32'd2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         push,
    input  logic [DW-1:0]                push_data,
    input  logic                         pop_ready,
    output logic [DW-1:0]                head,
    output logic                         head_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         drop
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] head_q, head_d;
    logic          valid_q, valid_d;
    logic          full_s, pop_s, push_ok_s;

    // Next-state FIFO control; a full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        full_s    = (count_q == CW'(DEPTH));
        pop_s     = valid_q && pop_ready;
        push_ok_s = push && (!full_s || pop_s);
        drop      = push && full_s && !pop_s;
        mem_d     = mem_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        valid_d = (count_d != '0);
        if (valid_d) begin
            head_d = mem_d[rd_ptr_d];
        end else begin
            head_d = '0;
        end
    end

    // FIFO state and registered head.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    assign head       = head_q;
    assign head_valid = valid_q;
    assign count      = count_q;

endmodule

// File: rtl/serial_word_packer.sv
// Bit-serial to word-parallel packer: assembles qualified serial bits into words and buffers them.
module serial_word_packer
    import chipdev_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = DEFAULT_DATA_SIZE,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned FIFO_DEPTH = 32'd2
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              din,
    input  logic                              din_valid,
    input  logic                              sync,
    output logic [DATA_SIZE-1:0]              dout,
    output logic                              dout_valid,
    input  logic                              dout_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fill_level,
    output logic                              overflow,
    input  logic                              clr_overflow
);

    localparam int unsigned CNT_W = $clog2(DATA_SIZE);

    logic [DATA_SIZE-1:0] shift_q, shift_d, base_s, ins_s;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 overflow_q, overflow_d;
    logic                 push_s, drop_s;

    // Shift/count next state; sync restarts the word and suppresses a coincident completion.
    always_comb begin
        base_s = sync ? '0 : shift_q;
        if (MSB_FIRST) begin
            ins_s = {base_s[DATA_SIZE-2:0], din};
        end else begin
            ins_s = {din, base_s[DATA_SIZE-1:1]};
        end
        push_s = 1'b0;
        if (din_valid) begin
            if (!sync && (bit_cnt_q == CNT_W'(DATA_SIZE - 1))) begin
                push_s    = 1'b1;
                shift_d   = '0;
                bit_cnt_d = '0;
            end else begin
                shift_d   = ins_s;
                bit_cnt_d = (sync ? '0 : bit_cnt_q) + CNT_W'(1);
            end
        end else if (sync) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else begin
            shift_d   = shift_q;
            bit_cnt_d = bit_cnt_q;
        end
    end

    // Sticky overflow; a drop on the same edge as a clear keeps the flag set.
    always_comb begin
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Assembly state and overflow flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    word_fifo #(
        .DW    (DATA_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (push_s),
        .push_data  (ins_s),
        .pop_ready  (dout_ready),
        .head       (dout),
        .head_valid (dout_valid),
        .count      (fill_level),
        .drop       (drop_s)
    );

    assign overflow = overflow_q;

endmodule
